// File: rtl/ov_cam_init.sv
// ov_cam_init: walks a {subaddr, data} register table after reset and issues
// one SCCB write per entry, with inline delay entries and an end marker.
// Optional feature macro: OV_INIT_READBACK_EN (read back and verify each write).
module ov_cam_init #(
    parameter logic [7:0]  DEV_ADDR     = 8'h42,
    parameter int unsigned PWRUP_CYCLES = 1_000_000,
    parameter int unsigned DELAY_UNIT   = 50_000,
    parameter int unsigned IDX_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [15:0]      tbl_entry,
    output logic [7:0]       addr,
    output logic [7:0]       subaddr,
    output logic [7:0]       w_data,
    output logic             tr_start,
    input  logic             tr_end,
    input  logic [7:0]       r_data,
    output logic             busy,
    output logic             done,
    output logic [7:0]       err_cnt
);

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned TO_W    = 2;
    localparam int unsigned RETRY_W = 2;
    localparam logic [TO_W-1:0]    ACK_TO_LAST = 2'd3;
    localparam logic [RETRY_W-1:0] MAX_RETRY   = 2'd3;
    localparam logic [7:0]         DELAY_SUB   = 8'hF0;
    localparam logic [15:0]        END_MARK    = 16'hFFFF;

    typedef enum logic [3:0] {
        S_PWRUP,
        S_FETCH,
        S_START,
        S_BUSY,
        S_WAIT,
        S_DELAY,
        S_DONE
`ifdef OV_INIT_READBACK_EN
        , S_RB_START,
        S_RB_BUSY,
        S_RB_WAIT
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   tbl_idx_q, tbl_idx_d;
    logic [7:0]         addr_q, addr_d;
    logic [7:0]         subaddr_q, subaddr_d;
    logic [7:0]         w_data_q, w_data_d;
    logic               tr_start_q, tr_start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               advance;
`ifdef OV_INIT_READBACK_EN
    logic [7:0]         err_cnt_q, err_cnt_d;
`endif

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_PWRUP;
            tbl_idx_q  <= '0;
            addr_q     <= DEV_ADDR;
            subaddr_q  <= '0;
            w_data_q   <= '0;
            tr_start_q <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            to_q       <= '0;
            retry_q    <= '0;
        end else begin
            state_q    <= state_d;
            tbl_idx_q  <= tbl_idx_d;
            addr_q     <= addr_d;
            subaddr_q  <= subaddr_d;
            w_data_q   <= w_data_d;
            tr_start_q <= tr_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            retry_q    <= retry_d;
        end
    end

`ifdef OV_INIT_READBACK_EN
    // Saturating readback mismatch counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end
`endif

    // Next-state and output logic; 'advance' moves to the next entry or ends on wrap.
    always_comb begin
        state_d    = state_q;
        tbl_idx_d  = tbl_idx_q;
        addr_d     = addr_q;
        subaddr_d  = subaddr_q;
        w_data_d   = w_data_q;
        tr_start_d = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        cnt_d      = cnt_q;
        to_d       = to_q;
        retry_d    = retry_q;
        advance    = 1'b0;
`ifdef OV_INIT_READBACK_EN
        err_cnt_d  = err_cnt_q;
`endif
        unique case (state_q)
            S_PWRUP: begin
                if (cnt_q + CNT_W'(1) >= CNT_W'(PWRUP_CYCLES)) begin
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FETCH: begin
                retry_d = '0;
                if (tbl_entry == END_MARK) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (tbl_entry[15:8] == DELAY_SUB) begin
                    cnt_d   = CNT_W'(tbl_entry[7:0]) * CNT_W'(DELAY_UNIT);
                    state_d = S_DELAY;
                end else begin
                    subaddr_d = tbl_entry[15:8];
                    w_data_d  = tbl_entry[7:0];
                    state_d   = S_START;
                end
            end
            S_START: begin
                addr_d = DEV_ADDR;
                if (tr_end) begin
                    tr_start_d = 1'b1;
                    to_d       = '0;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!tr_end) begin
                    state_d = S_WAIT;
                end else if (to_q == ACK_TO_LAST) begin
                    if (retry_q == MAX_RETRY) begin
                        advance = 1'b1;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = S_START;
                    end
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_WAIT: begin
                if (tr_end) begin
`ifdef OV_INIT_READBACK_EN
                    retry_d = '0;
                    addr_d  = DEV_ADDR | 8'h01;
                    state_d = S_RB_START;
`else
                    advance = 1'b1;
`endif
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (start) begin
                    tbl_idx_d = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    state_d   = S_FETCH;
                end
            end
`ifdef OV_INIT_READBACK_EN
            S_RB_START: begin
                if (tr_end) begin
                    tr_start_d = 1'b1;
                    to_d       = '0;
                    state_d    = S_RB_BUSY;
                end
            end
            S_RB_BUSY: begin
                if (!tr_end) begin
                    state_d = S_RB_WAIT;
                end else if (to_q == ACK_TO_LAST) begin
                    if (retry_q == MAX_RETRY) begin
                        addr_d  = DEV_ADDR;
                        advance = 1'b1;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = S_RB_START;
                    end
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_RB_WAIT: begin
                if (tr_end) begin
                    if ((r_data != w_data_q) && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    addr_d  = DEV_ADDR;
                    advance = 1'b1;
                end
            end
`endif
            default: state_d = S_PWRUP;
        endcase
        if (advance) begin
            if (tbl_idx_q == '1) begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                tbl_idx_d = tbl_idx_q + IDX_W'(1);
                state_d   = S_FETCH;
            end
        end
    end

    assign tbl_idx  = tbl_idx_q;
    assign addr     = addr_q;
    assign subaddr  = subaddr_q;
    assign w_data   = w_data_q;
    assign tr_start = tr_start_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef OV_INIT_READBACK_EN
    assign err_cnt = err_cnt_q;
`else
    // Read data is only consumed by the readback path.
    logic unused_rdata;
    assign unused_rdata = ^r_data;
    assign err_cnt      = '0;
`endif

endmodule

// File: doc/ov_cam_init.md
# ov_cam_init

Register-initialisation sequencer that sits directly upstream of the SCCB master. After reset it walks a register table of {subaddr, data} pairs and issues one SCCB write per entry by driving the master's `addr`, `subaddr`, `w_data` and `tr_start`, handshaking on `tr_end`. It supports inline delay entries and an end marker, and reports completion to the camera bring-up logic.

## Interface
Parameters:
- `DEV_ADDR`, 8'h42: 8-bit SCCB device write address (bit 0 = 0).
- `PWRUP_CYCLES`, 1_000_000: clocks to wait after reset before the first transaction.
- `DELAY_UNIT`, 50_000: clocks per delay-entry count.
- `IDX_W`, 8: width of the table index.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; re-runs the sequence from index 0 when high in `S_DONE`.
- `tbl_idx`  out  IDX_W  current table index.
- `tbl_entry`  in  16  `{subaddr, data}` at `tbl_idx`. Combinational table; valid the same cycle.
- `addr`  out  8  to SCCB master.
- `subaddr`  out  8  to SCCB master.
- `w_data`  out  8  to SCCB master.
- `tr_start`  out  1  one-cycle transaction request.
- `tr_end`  in  1  SCCB master idle flag. High means idle.
- `r_data`  in  8  SCCB read data. Used only with readback.
- `busy`  out  1  high from reset release until `S_DONE`.
- `done`  out  1  high in `S_DONE`.
- `err_cnt`  out  8  readback mismatch count. Constant 0 without the macro.

## Operation
- Reset values:
  - state `S_PWRUP`; `tbl_idx`=0.
  - `addr`=DEV_ADDR; `subaddr`=0; `w_data`=0.
  - `tr_start`=0; `busy`=1; `done`=0; `err_cnt`=0.
  - Delay counter cleared.
- Reset mid-operation:
  - Aborts immediately to the reset values.
  - No `tr_start` is issued for 1+PWRUP_CYCLES clocks after release.
- States:
  - `S_PWRUP`: counts PWRUP_CYCLES, then `S_FETCH`.
  - `S_FETCH`: registers `tbl_entry`.
    - `16'hFFFF` → `S_DONE` (end marker).
    - `subaddr`==8'hF0 → `S_DELAY`, loading `data`×DELAY_UNIT. A `data` of 0 means zero wait: `S_DELAY` exits next cycle.
    - Otherwise drive `subaddr`/`w_data` and go to `S_START`.
  - `S_START`: waits until `tr_end`=1. Then pulses `tr_start` for exactly one cycle with `addr`=DEV_ADDR → `S_BUSY`.
  - `S_BUSY`: waits for `tr_end`=0, which is the master's acknowledgement, → `S_WAIT`.
  - `S_WAIT`: waits for `tr_end`=1.
    - Increments `tbl_idx`, then `S_FETCH`.
    - With the macro, goes to `S_RB_START` instead.
  - `S_DELAY`: counts down to 0. Then increments `tbl_idx` → `S_FETCH`.
  - `S_DONE`: `done`=1, `busy`=0. When `start`=1: `tbl_idx`←0, `busy`←1 → `S_FETCH`. There is no power-up wait on a re-run.
- `tbl_idx` wrap-around: incrementing from 2^IDX_W−1 forces `S_DONE`. The sequencer never re-reads index 0 unprompted.
- `addr`, `subaddr` and `w_data` are held stable from `tr_start` until `tr_end` returns high.

## Timing
- Table fetch: 1 cycle.
- `tr_start` rises ≥1 cycle after `S_FETCH` and lasts exactly 1 cycle.
- Ack timeout: if `tr_end` stays high for 4 cycles in `S_BUSY`, return to `S_START` and retry. Maximum 3 retries; after that, skip the entry and continue.
- Per-entry overhead beyond the SCCB transaction: 3 cycles (fetch, start, index update).
- Delay entry `n`: n×DELAY_UNIT+2 cycles from fetch to next fetch.
- `done` asserts the cycle after the end marker is fetched.

## Configuration
- Macro: `OV_INIT_READBACK_EN`.
- Defined: each write is followed by a read transaction.
  - Sequence: `S_RB_START` → `S_RB_BUSY` → `S_RB_WAIT`, using `addr`=DEV_ADDR|1 and the same handshake as the write.
  - On completion, compare `r_data` with `w_data`. On mismatch, increment `err_cnt`, saturating at 8'hFF.
  - Restore `addr`=DEV_ADDR before the next fetch.
- Undefined: readback states are absent; `err_cnt` is tied to 0.

## Test plan
- Reset, PWRUP_CYCLES=10, table {12:80, 11:01, FFFF}, SCCB model with 20-cycle busy:
  - no `tr_start` before cycle 11;
  - exactly two pulses, carrying 12/80 then 11/01;
  - `done`=1 after the second `tr_end` rise.
- Entry F0:03 with DELAY_UNIT=4 between two writes → gap of 3×4+2 cycles between the second `tr_end` rise and the next fetch.
- Model never drops `tr_end` → 4 `tr_start` pulses total on that entry (1 + 3 retries), then `tbl_idx` advances.
- Reset pulsed low mid-`S_WAIT` → all outputs at reset values the same cycle; sequence restarts with the power-up wait.
- In `S_DONE`, `start`=1 → `tbl_idx`=0, `busy`=1, first `tr_start` within 3 cycles.
- With `OV_INIT_READBACK_EN`, model returns `w_data`^1 for entry 2 only → `err_cnt`=1; read transactions use `addr`=8'h43.
